// File: rtl/main_mem_pkg.sv
// Shared constants, address slicing helpers and request types for the banked
// main memory crossbar.
package main_mem_pkg;
    localparam int NUM_PORT    = 4;
    localparam int NUM_REQ     = NUM_PORT + 1;
    localparam int NUM_REGION  = 64;
    localparam int NUM_LANE    = 4;
    localparam int ROW_BITS    = 12;
    localparam int REGION_BITS = $clog2(NUM_REGION);
    localparam int LANE_BITS   = $clog2(NUM_LANE);
    localparam int WORD_BITS   = ROW_BITS + LANE_BITS;
    localparam int PTR_BITS    = $clog2(NUM_REQ);
    localparam int LINE_W      = 32 * NUM_LANE;

    typedef logic [NUM_LANE-1:0][31:0] line_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        line_t       wdata;
    } mem_req_t;

    function automatic logic [REGION_BITS-1:0] addr_region(input logic [31:0] a);
        return a[WORD_BITS+2 +: REGION_BITS];
    endfunction

    function automatic logic [WORD_BITS-1:0] addr_word(input logic [31:0] a);
        return a[WORD_BITS+1:2];
    endfunction

    function automatic logic [LANE_BITS-1:0] word_lane(input logic [WORD_BITS-1:0] w);
        return w[LANE_BITS-1:0];
    endfunction

    function automatic logic [ROW_BITS-1:0] word_row(input logic [WORD_BITS-1:0] w);
        return w[WORD_BITS-1:LANE_BITS];
    endfunction
endpackage

// File: rtl/main_mem_rr_arb.sv
// Round-robin grant for one region: first requester at or after ptr_i wins.
module main_mem_rr_arb
    import main_mem_pkg::*;
(
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [PTR_BITS-1:0] ptr_i,
    output logic [NUM_REQ-1:0]  gnt_o
);
    logic [PTR_BITS:0]   sum;
    logic [PTR_BITS-1:0] idx;
    logic                found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_i} + (PTR_BITS+1)'(i);
            if (sum >= (PTR_BITS+1)'(NUM_REQ)) sum = sum - (PTR_BITS+1)'(NUM_REQ);
            idx = sum[PTR_BITS-1:0];
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/single_port_ram.sv
// Single-port lane RAM with registered read data (one lane of one region).
module single_port_ram #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
        dout <= mem[addr];
    end
endmodule

// File: rtl/main_mem_xbar.sv
// Banked main memory crossbar: per-region round-robin arbitration, 128-bit
// lines at any word alignment, fixed 3-cycle in-order responses per port.
module main_mem_xbar
    import main_mem_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_PORT-1:0]                rt_req_valid,
    input  logic [NUM_PORT-1:0]                rt_req_we,
    input  logic [NUM_PORT-1:0][31:0]          rt_req_addr,
    input  logic [NUM_PORT-1:0][LINE_W-1:0]    rt_req_wdata,
    output logic [NUM_PORT-1:0]                rt_req_ready,
    output logic [NUM_PORT-1:0]                rt_resp_valid,
    output logic [NUM_PORT-1:0][LINE_W-1:0]    rt_resp_rdata,
    input  logic                               mc_req_valid,
    input  logic [31:0]                        mc_req_addr,
    output logic                               mc_req_ready,
    output logic                               mc_resp_valid,
    output logic [LINE_W-1:0]                  mc_resp_rdata,
    output logic [PTR_BITS-1:0]                dbg_rr_ptr_o
);
    // Handshake: a request moves when valid and ready are both high at a clock
    // edge; a refused requester keeps valid/we/addr/wdata stable until ready.
    mem_req_t                                  req [NUM_REQ];
    logic [NUM_REQ-1:0]                        cand, gnt;
    logic [NUM_REGION-1:0][NUM_REQ-1:0]        region_req, region_gnt;
    logic [PTR_BITS-1:0]                       rr_ptr_q, rr_ptr_d;

    logic [NUM_REGION-1:0]                     s1_we_d, s1_we_q;
    logic [NUM_REGION-1:0][NUM_LANE-1:0][ROW_BITS-1:0] s1_row_d, s1_row_q;
    logic [NUM_REGION-1:0][NUM_LANE-1:0][31:0] s1_data_d, s1_data_q, ram_q;

    logic [NUM_REQ-1:0]                        req_we;
    logic [NUM_REQ-1:0][REGION_BITS-1:0]       req_region;
    logic [NUM_REQ-1:0][LANE_BITS-1:0]         req_rot;
    logic [NUM_REQ-1:0]                        p1_vld_q, p2_vld_q, p1_we_q, p2_we_q;
    logic [NUM_REQ-1:0][REGION_BITS-1:0]       p1_region_q, p2_region_q;
    logic [NUM_REQ-1:0][LANE_BITS-1:0]         p1_rot_q, p2_rot_q;
    logic [NUM_REQ-1:0]                        resp_vld_q;
    logic [NUM_REQ-1:0][LINE_W-1:0]            resp_data_d, resp_data_q;

    logic [REGION_BITS-1:0]                    sel_region;
    logic [WORD_BITS-1:0]                      sel_word, word_k;
    line_t                                     rot_line;

    always_comb begin
        region_req = '0;
        for (int j = 0; j < NUM_PORT; j++) begin
            req[j]  = '{we: rt_req_we[j], addr: rt_req_addr[j], wdata: rt_req_wdata[j]};
            cand[j] = rt_req_valid[j] & ~rst;
        end
        req[NUM_PORT]  = '{we: 1'b0, addr: mc_req_addr, wdata: '0};
        cand[NUM_PORT] = mc_req_valid & ~rst;
        for (int j = 0; j < NUM_REQ; j++) begin
            req_we[j]     = req[j].we;
            req_region[j] = addr_region(req[j].addr);
            req_rot[j]    = word_lane(addr_word(req[j].addr));
            region_req[req_region[j]][j] = cand[j];
        end
    end

    for (genvar r = 0; r < NUM_REGION; r++) begin : g_arb
        main_mem_rr_arb u_arb (
            .req_i (region_req[r]),
            .ptr_i (rr_ptr_q),
            .gnt_o (region_gnt[r])
        );
    end

    always_comb begin
        gnt = '0;
        for (int r = 0; r < NUM_REGION; r++) gnt = gnt | region_gnt[r];
        rr_ptr_d = rr_ptr_q;
        if (|(cand & ~gnt))
            rr_ptr_d = (rr_ptr_q == PTR_BITS'(NUM_REQ-1)) ? '0 : rr_ptr_q + 1'b1;
    end

    // Steer each granted line onto its region's lanes; word k lands in lane
    // (w+k) mod NUM_LANE, wrapping to row 0 past the region end.
    always_comb begin
        s1_we_d    = '0;
        s1_row_d   = '0;
        s1_data_d  = '0;
        sel_region = '0;
        sel_word   = '0;
        word_k     = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (gnt[j]) begin
                sel_region = req_region[j];
                sel_word   = addr_word(req[j].addr);
                s1_we_d[sel_region] = req[j].we;
                for (int k = 0; k < NUM_LANE; k++) begin
                    word_k = sel_word + WORD_BITS'(k);
                    s1_row_d[sel_region][word_lane(word_k)]  = word_row(word_k);
                    s1_data_d[sel_region][word_lane(word_k)] = req[j].wdata[k];
                end
            end
        end
    end

    for (genvar r = 0; r < NUM_REGION; r++) begin : g_region
        for (genvar l = 0; l < NUM_LANE; l++) begin : g_lane
            single_port_ram #(.ADDR_WIDTH(ROW_BITS), .DATA_WIDTH(32)) u_ram (
                .clk  (clk),
                .we   (s1_we_q[r]),
                .addr (s1_row_q[r][l]),
                .din  (s1_data_q[r][l]),
                .dout (ram_q[r][l])
            );
        end
    end

    always_comb begin
        rot_line    = '0;
        resp_data_d = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            for (int k = 0; k < NUM_LANE; k++)
                rot_line[k] = ram_q[p2_region_q[j]][p2_rot_q[j] + LANE_BITS'(k)];
            resp_data_d[j] = p2_we_q[j] ? '0 : rot_line;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            s1_we_q     <= '0;
            p1_vld_q    <= '0;
            p2_vld_q    <= '0;
            resp_vld_q  <= '0;
            resp_data_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            s1_we_q     <= s1_we_d;
            p1_vld_q    <= gnt;
            p2_vld_q    <= p1_vld_q;
            resp_vld_q  <= p2_vld_q;
            resp_data_q <= resp_data_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_row_q    <= s1_row_d;
        s1_data_q   <= s1_data_d;
        p1_we_q     <= req_we;
        p1_region_q <= req_region;
        p1_rot_q    <= req_rot;
        p2_we_q     <= p1_we_q;
        p2_region_q <= p1_region_q;
        p2_rot_q    <= p1_rot_q;
    end

    // Address bits outside the word/region fields are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rt_req_addr, mc_req_addr};

    assign rt_req_ready  = gnt[NUM_PORT-1:0];
    assign mc_req_ready  = gnt[NUM_PORT];
    assign rt_resp_valid = resp_vld_q[NUM_PORT-1:0];
    assign mc_resp_valid = resp_vld_q[NUM_PORT];
    assign rt_resp_rdata = resp_data_q[NUM_PORT-1:0];
    assign mc_resp_rdata = resp_data_q[NUM_PORT];
    assign dbg_rr_ptr_o  = rr_ptr_q;
endmodule

// File: tb/tb_main_mem_xbar.sv
// Scoreboard bench for main_mem_xbar: directed scenarios plus random traffic
// against a word-addressed memory model and a rule-level arbitration model.
module tb_main_mem_xbar;
    import main_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]  vld = '0;
    logic [NUM_REQ-1:0]  we  = '0;
    logic [31:0]         addr  [NUM_REQ];
    logic [LINE_W-1:0]   wdata [NUM_REQ];

    logic [NUM_PORT-1:0]             rt_req_valid, rt_req_we, rt_req_ready, rt_resp_valid;
    logic [NUM_PORT-1:0][31:0]       rt_req_addr;
    logic [NUM_PORT-1:0][LINE_W-1:0] rt_req_wdata, rt_resp_rdata;
    logic                            mc_req_ready, mc_resp_valid;
    logic [LINE_W-1:0]               mc_resp_rdata;
    logic [PTR_BITS-1:0]             dbg_rr_ptr;

    assign rt_req_valid = vld[NUM_PORT-1:0];
    assign rt_req_we    = we[NUM_PORT-1:0];
    for (genvar g = 0; g < NUM_PORT; g++) begin : g_drv
        assign rt_req_addr[g]  = addr[g];
        assign rt_req_wdata[g] = wdata[g];
    end

    main_mem_xbar dut (
        .clk           (clk),
        .rst           (rst),
        .rt_req_valid  (rt_req_valid),
        .rt_req_we     (rt_req_we),
        .rt_req_addr   (rt_req_addr),
        .rt_req_wdata  (rt_req_wdata),
        .rt_req_ready  (rt_req_ready),
        .rt_resp_valid (rt_resp_valid),
        .rt_resp_rdata (rt_resp_rdata),
        .mc_req_valid  (vld[NUM_PORT]),
        .mc_req_addr   (addr[NUM_PORT]),
        .mc_req_ready  (mc_req_ready),
        .mc_resp_valid (mc_resp_valid),
        .mc_resp_rdata (mc_resp_rdata),
        .dbg_rr_ptr_o  (dbg_rr_ptr)
    );

    logic [NUM_REQ-1:0]             ready_v, resp_v;
    logic [NUM_REQ-1:0][LINE_W-1:0] resp_d;
    assign ready_v = {mc_req_ready, rt_req_ready};
    assign resp_v  = {mc_resp_valid, rt_resp_valid};
    assign resp_d  = {mc_resp_rdata, rt_resp_rdata};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    logic mon_en = 1'b0;

    logic [LINE_W-1:0] exp_q [NUM_REQ][$];
    logic [LINE_W-1:0] msk_q [NUM_REQ][$];
    int                due_q [NUM_REQ][$];

    logic [31:0]        mem_m [int];
    int                 ptr_m = 0;
    logic [NUM_REQ-1:0] acc = '0;
    logic [NUM_REQ-1:0] rdy_seen = '0;

    // Monitor: pops one expectation per response strobe, flags late/missing ones.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                while (due_q[j].size() > 0 && due_q[j][0] < cyc) begin
                    n_checks++; n_fail++;
                    $display("FAIL resp_missing port %0d: no resp_valid seen, required at cycle %0d (now %0d)",
                             j, due_q[j][0], cyc);
                    void'(exp_q[j].pop_front()); void'(msk_q[j].pop_front()); void'(due_q[j].pop_front());
                end
                if (resp_v[j]) begin
                    n_checks++;
                    if (due_q[j].size() == 0) begin
                        n_fail++;
                        $display("FAIL resp_unexpected port %0d cycle %0d: got resp_valid=1, required 0", j, cyc);
                    end else begin
                        logic [LINE_W-1:0] e, m;
                        int d;
                        e = exp_q[j].pop_front(); m = msk_q[j].pop_front(); d = due_q[j].pop_front();
                        if (d != cyc || ((resp_d[j] ^ e) & m) != '0) begin
                            n_fail++;
                            $display("FAIL resp_data port %0d cycle %0d: got %h, required %h (mask %h, due %0d)",
                                     j, cyc, resp_d[j], e, m, d);
                        end
                    end
                end
            end
        end
    end

    function automatic int region_of(input logic [31:0] a);
        return int'((a >> 16) & 32'h3F);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) & 32'h3FFF);
    endfunction

    // One clock of the reference model: grants, ready check, expectations, memory update.
    task automatic step();
        logic [NUM_REQ-1:0] cand, gnt_m;
        bit                 taken [NUM_REGION];
        logic [LINE_W-1:0]  e, m;
        int                 j, key;
        @(negedge clk); #1;
        n_checks++;
        if (dbg_rr_ptr != PTR_BITS'(ptr_m)) begin
            n_fail++;
            $display("FAIL rr_ptr cycle %0d: got %0d, required %0d", cyc, dbg_rr_ptr, ptr_m);
        end
        cand  = rst ? '0 : vld;
        gnt_m = '0;
        foreach (taken[r]) taken[r] = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            j = (ptr_m + off) % NUM_REQ;
            if (cand[j] && !taken[region_of(addr[j])]) begin
                gnt_m[j] = 1'b1;
                taken[region_of(addr[j])] = 1'b1;
            end
        end
        rdy_seen = ready_v;
        n_checks++;
        if (ready_v !== gnt_m) begin
            n_fail++;
            $display("FAIL ready cycle %0d: got %b, required %b", cyc, ready_v, gnt_m);
        end
        for (int p = 0; p < NUM_REQ; p++) begin
            if (gnt_m[p]) begin
                e = '0; m = '1;
                if (!we[p]) begin
                    for (int k = 0; k < NUM_LANE; k++) begin
                        key = region_of(addr[p]) * 16384 + (word_of(addr[p]) + k) % 16384;
                        if (mem_m.exists(key)) e[k*32 +: 32] = mem_m[key];
                        else m[k*32 +: 32] = '0;
                    end
                end
                exp_q[p].push_back(e); msk_q[p].push_back(m); due_q[p].push_back(cyc + 3);
            end
        end
        for (int p = 0; p < NUM_REQ; p++) begin
            if (gnt_m[p] && we[p]) begin
                for (int k = 0; k < NUM_LANE; k++) begin
                    key = region_of(addr[p]) * 16384 + (word_of(addr[p]) + k) % 16384;
                    mem_m[key] = wdata[p][k*32 +: 32];
                end
            end
        end
        if (rst) begin
            ptr_m = 0;
            for (int p = 0; p < NUM_REQ; p++) begin
                while (due_q[p].size() > 0 && due_q[p][$] > cyc) begin
                    void'(exp_q[p].pop_back()); void'(msk_q[p].pop_back()); void'(due_q[p].pop_back());
                end
            end
        end else if ((cand & ~gnt_m) != '0) begin
            ptr_m = (ptr_m + 1) % NUM_REQ;
        end
        acc = gnt_m;
        @(posedge clk); #1;
    endtask

    task automatic drive(input int j, input logic w, input logic [31:0] a, input logic [LINE_W-1:0] d);
        vld[j] = 1'b1; we[j] = w; addr[j] = a; wdata[j] = d;
    endtask

    function automatic logic [LINE_W-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Step until every pending request has been accepted, bounded.
    task automatic settle();
        for (int i = 0; i < 20 && vld != '0; i++) begin
            step();
            vld = vld & ~acc;
        end
        n_checks++;
        if (vld != '0) begin
            n_fail++;
            $display("FAIL settle_timeout: requests still pending %b, required none", vld);
            vld = '0;
        end
    endtask

    task automatic idle(input int n);
        vld = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_cycle();
        int r, w;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!vld[j] || acc[j]) begin
                vld[j] = ($urandom_range(0, 3) != 0);
                r = 8 + $urandom_range(0, 3);
                w = $urandom_range(0, 1) ? $urandom_range(0, 11) : 16384 - $urandom_range(1, 6);
                addr[j]  = ($urandom & 32'hFFC0_0000) | (r << 16) | (w << 2) | $urandom_range(0, 3);
                we[j]    = (j < NUM_PORT) ? 1'($urandom_range(0, 1)) : 1'b0;
                wdata[j] = rnd_line();
            end
        end
        step();
    endtask

    int g0, g4;

    initial begin
        for (int j = 0; j < NUM_REQ; j++) begin addr[j] = '0; wdata[j] = '0; end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Unaligned write then reads at the same and the preceding word.
        drive(0, 1'b1, 32'h0001_0004, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
        step(); vld[0] = 1'b0;
        drive(2, 1'b0, 32'h0001_0004, '0);
        step();
        drive(2, 1'b0, 32'h0001_0000, '0);
        settle(); idle(4);

        // Region wrap, with a neighbouring region that must stay intact.
        drive(1, 1'b1, 32'h0003_0000, rnd_line()); settle();
        drive(1, 1'b1, 32'h0002_FFFC, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
        settle();
        drive(3, 1'b0, 32'h0002_FFFC, '0);
        drive(2, 1'b0, 32'h0002_0000, '0);
        drive(0, 1'b0, 32'h0003_0000, '0);
        drive(4, 1'b0, 32'h0003_FFF8, '0);
        settle(); idle(4);

        // Collision right after reset on region 5.
        drive(0, 1'b1, 32'h0005_0010, rnd_line()); settle(); idle(4);
        rst = 1'b1; step(); rst = 1'b0;
        drive(0, 1'b0, 32'h0005_0010, '0);
        drive(1, 1'b0, 32'h0005_0014, '0);
        settle(); idle(4);

        // All requesters in distinct regions in one cycle.
        drive(0, 1'b1, 32'h0000_0100, rnd_line());
        drive(1, 1'b0, 32'h0001_0004, '0);
        drive(2, 1'b1, 32'h0002_0200, rnd_line());
        drive(3, 1'b0, 32'h0003_0000, '0);
        drive(4, 1'b0, 32'h0004_0000, '0);
        settle(); idle(4);

        // Port 0 and MC hammer region 7; both must keep getting grants.
        g0 = 0; g4 = 0;
        drive(0, 1'b0, 32'h0007_0000, '0);
        drive(4, 1'b0, 32'h0007_0040, '0);
        for (int i = 0; i < 15; i++) begin
            step();
            if (rdy_seen[0]) begin g0++; addr[0] = 32'h0007_0000 | ($urandom_range(0, 63) << 2); end
            if (rdy_seen[4]) begin g4++; addr[4] = 32'h0007_0000 | ($urandom_range(0, 63) << 2); end
        end
        vld = '0;
        n_checks++;
        if (g0 < 2 || g4 < 2) begin
            n_fail++;
            $display("FAIL mc_fairness: grants port0=%0d mc=%0d, required at least 2 each", g0, g4);
        end
        idle(4);

        // Reset one cycle after four accepted reads: responses are dropped.
        drive(0, 1'b0, 32'h0001_0004, '0);
        drive(1, 1'b0, 32'h0002_FFFC, '0);
        drive(2, 1'b0, 32'h0003_0000, '0);
        drive(3, 1'b0, 32'h0005_0010, '0);
        step(); vld = '0;
        rst = 1'b1; step(); rst = 1'b0;
        idle(6);
        drive(1, 1'b0, 32'h0001_0004, '0);
        settle(); idle(4);

        // Random traffic on a few regions with line-end wrap addresses.
        for (int i = 0; i < 400; i++) rand_cycle();
        idle(8);

        for (int j = 0; j < NUM_REQ; j++) begin
            n_checks++;
            if (due_q[j].size() != 0) begin
                n_fail++;
                $display("FAIL drain port %0d: %0d responses outstanding, required 0", j, due_q[j].size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
